// File: rtl/vault_pkg.sv
// Shared types and constants for the five-phase vault controller.
// Sequence constants are packed with element 0 in the least-significant slot.
package vault_pkg;

  typedef enum logic [2:0] {
    ST_CODE     = 3'd0,
    ST_SWITCH   = 3'd1,
    ST_MAZE     = 3'd2,
    ST_PLATES   = 3'd3,
    ST_TIMELOCK = 3'd4,
    ST_DONE     = 3'd5,
    ST_ALARM    = 3'd6
  } phase_t;

  // Oldest code bit sits in the MSB
  localparam logic [3:0] CODE_SEQ   = 4'b1011;
  localparam logic [3:0] SWITCH_KEY = 4'b1101;

  localparam int MAZE_W   = 3;
  localparam int MAZE_LEN = 5;
  localparam logic [MAZE_W*MAZE_LEN-1:0] MAZE_SEQ =
    {3'b000, 3'b010, 3'b001, 3'b011, 3'b000};

  localparam int PLATE_W   = 8;
  localparam int PLATE_LEN = 3;
  localparam logic [PLATE_W*PLATE_LEN-1:0] PLATE_SEQ =
    {8'hF0, 8'hCC, 8'hAA};

  localparam int DEF_MAX_ERRORS     = 3;
  localparam int DEF_TL_STEP        = 4;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vault_seq_tracker.sv
// Tracks entry of a fixed value sequence: accepts matches, tolerates repeats of
// the last accepted value, and flags anything else as an error.
module vault_seq_tracker
  import vault_pkg::*;
#(
  parameter int                       WIDTH     = 3,
  parameter int                       LENGTH    = 5,
  parameter logic [WIDTH*LENGTH-1:0]  SEQ       = '0,
  parameter bit                       IDLE_ZERO = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] sample,
  output logic             done,
  output logic             error
);

  localparam int IW = cnt_width(LENGTH);

  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] last;
  logic             has_last;
  logic [WIDTH-1:0] expected;
  logic             is_idle;
  logic             is_match;
  logic             is_hold;

  always_comb begin
    expected = SEQ[int'(idx)*WIDTH +: WIDTH];
    is_idle  = IDLE_ZERO && (sample == '0);
    is_match = !is_idle && (sample == expected);
    is_hold  = !is_idle && !is_match && has_last && (sample == last);
    error    = enable && !is_idle && !is_match && !is_hold;
    done     = enable && is_match && (idx == IW'(LENGTH - 1));
  end

  // An error restarts the sequence and forgets the last accepted value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx      <= '0;
      last     <= '0;
      has_last <= 1'b0;
    end else if (enable) begin
      if (is_match) begin
        last     <= sample;
        has_last <= 1'b1;
        idx      <= done ? '0 : idx + IW'(1);
      end else if (error) begin
        idx      <= '0;
        has_last <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/vault_top.sv
// Vault puzzle controller: code lock, switch room, maze, plates, time lock.
// Optional per-phase timeout hardware is built when VAULT_TIMEOUT_EN is defined.
module vault_top
  import vault_pkg::*;
#(
  parameter int MAX_ERRORS     = DEF_MAX_ERRORS,
  parameter int TL_STEP        = DEF_TL_STEP
`ifdef VAULT_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       code_in,
  input  logic [3:0] switch_in,
  input  logic [2:0] dir_in,
  input  logic [7:0] plate_in,
  output logic [1:0] time_lock_out,
  output logic       all_done,
  output logic       alarm
);

  localparam int EW = cnt_width(MAX_ERRORS + 1);
  localparam int SW = cnt_width(TL_STEP);

  phase_t        state;
  phase_t        next_state;
  logic [2:0]    code_hist;
  logic          code_hit;
  logic          maze_done;
  logic          maze_err;
  logic          plate_done;
  logic          plate_err;
  logic [EW-1:0] err_cnt;
  logic [EW-1:0] err_next;
  logic [SW-1:0] step_cnt;
  logic          step_wrap;
  logic [1:0]    tl_count;

  vault_seq_tracker #(
    .WIDTH     (MAZE_W),
    .LENGTH    (MAZE_LEN),
    .SEQ       (MAZE_SEQ),
    .IDLE_ZERO (1'b0)
  ) u_maze (
    .clk    (clk),
    .reset  (reset),
    .enable (state == ST_MAZE),
    .sample (dir_in),
    .done   (maze_done),
    .error  (maze_err)
  );

  vault_seq_tracker #(
    .WIDTH     (PLATE_W),
    .LENGTH    (PLATE_LEN),
    .SEQ       (PLATE_SEQ),
    .IDLE_ZERO (1'b1)
  ) u_plates (
    .clk    (clk),
    .reset  (reset),
    .enable (state == ST_PLATES),
    .sample (plate_in),
    .done   (plate_done),
    .error  (plate_err)
  );

  assign code_hit  = ({code_hist, code_in} == CODE_SEQ);
  assign step_wrap = (step_cnt == SW'(TL_STEP - 1));
  assign err_next  = ((maze_err || plate_err) && (err_cnt != EW'(MAX_ERRORS)))
                     ? err_cnt + EW'(1) : err_cnt;

`ifdef VAULT_TIMEOUT_EN
  localparam int TW = cnt_width(TIMEOUT_CYCLES);

  logic [TW-1:0] tmo_cnt;
  logic          timed_phase;
  logic          tmo_hit;

  assign timed_phase = (state == ST_SWITCH) || (state == ST_MAZE) || (state == ST_PLATES);
  assign tmo_hit     = timed_phase && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Restarts on every phase change, so each timed phase gets a fresh budget
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (next_state != state) begin
      tmo_cnt <= '0;
    end else if (timed_phase) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_CODE;
    end else begin
      state <= next_state;
    end
  end

  // Error-driven alarm overrides any phase advance decided in the same cycle
  always_comb begin
    next_state = state;
    case (state)
      ST_CODE:     if (code_hit) next_state = ST_SWITCH;
      ST_SWITCH:   if (switch_in == SWITCH_KEY) next_state = ST_MAZE;
      ST_MAZE:     if (maze_done) next_state = ST_PLATES;
      ST_PLATES:   if (plate_done) next_state = ST_TIMELOCK;
      ST_TIMELOCK: if (step_wrap && (tl_count == 2'd3)) next_state = ST_DONE;
      ST_DONE:     next_state = ST_DONE;
      ST_ALARM:    next_state = ST_ALARM;
      default:     next_state = ST_CODE;
    endcase
`ifdef VAULT_TIMEOUT_EN
    if (tmo_hit && (next_state == state)) next_state = ST_ALARM;
`endif
    if (err_next == EW'(MAX_ERRORS)) next_state = ST_ALARM;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_hist <= '0;
    end else if (state == ST_CODE) begin
      code_hist <= {code_hist[1:0], code_in};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt <= '0;
    end else begin
      err_cnt <= err_next;
    end
  end

  // Count 3 is held for a full step before the vault opens
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_cnt <= '0;
      tl_count <= 2'd0;
    end else if (next_state == ST_ALARM) begin
      step_cnt <= '0;
      tl_count <= 2'd0;
    end else if (state == ST_TIMELOCK) begin
      if (step_wrap) begin
        step_cnt <= '0;
        if (tl_count != 2'd3) tl_count <= tl_count + 2'd1;
      end else begin
        step_cnt <= step_cnt + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      all_done <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      all_done <= (next_state == ST_DONE);
      alarm    <= (next_state == ST_ALARM);
    end
  end

  assign time_lock_out = tl_count;

endmodule

// File: tb/tb_vault_top.sv
// Directed testbench for vault_top with hand-computed expectations.
// Covers happy path, code overlap, errors, holds, async reset and phase timeout.
module tb_vault_top;

  logic       clk;
  logic       reset = 1'b1;
  logic       code_in;
  logic [3:0] switch_in;
  logic [2:0] dir_in;
  logic [7:0] plate_in;
  logic [1:0] time_lock_out;
  logic       all_done;
  logic       alarm;

  int total = 0;
  int bad   = 0;

  logic [2:0] maze_dirs  [5] = '{3'b000, 3'b011, 3'b001, 3'b010, 3'b000};
  logic [7:0] plate_vals [3] = '{8'hAA, 8'hCC, 8'hF0};

  vault_top dut (
    .clk           (clk),
    .reset         (reset),
    .code_in       (code_in),
    .switch_in     (switch_in),
    .dir_in        (dir_in),
    .plate_in      (plate_in),
    .time_lock_out (time_lock_out),
    .all_done      (all_done),
    .alarm         (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] tl, input logic done, input logic alm);
    check_output({tag, "_tl"}, 8'(time_lock_out), 8'(tl));
    check_output({tag, "_done"}, 8'(all_done), 8'(done));
    check_output({tag, "_alarm"}, 8'(alarm), 8'(alm));
  endtask

  task automatic apply_reset();
    reset     = 1'b0;
    code_in   = 1'b0;
    switch_in = 4'b0000;
    dir_in    = 3'b000;
    plate_in  = 8'h00;
    tick(2);
    check_outs("reset", 2'd0, 1'b0, 1'b0);
    reset = 1'b1;
  endtask

  task automatic send_code(input logic [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      code_in = bits[i];
      tick(1);
    end
    code_in = 1'b0;
  endtask

  task automatic open_switch();
    switch_in = 4'b1101;
    tick(1);
    switch_in = 4'b0000;
  endtask

  task automatic maze_walk(input int hold);
    for (int k = 0; k < 5; k++) begin
      dir_in = maze_dirs[k];
      tick(hold);
    end
  endtask

  task automatic plate_walk(input int hold, input int gap);
    for (int k = 0; k < 3; k++) begin
      plate_in = plate_vals[k];
      tick(hold);
      if (gap > 0) begin
        plate_in = 8'h00;
        tick(gap);
      end
    end
    plate_in = 8'h00;
  endtask

  task automatic happy_to_timelock();
    send_code(8'b0000_1011, 4);
    open_switch();
    maze_walk(1);
    plate_walk(1, 0);
  endtask

  task automatic check_timelock();
    int exp_tl;
    for (int i = 1; i <= 16; i++) begin
      tick(1);
      exp_tl = (i >= 12) ? 3 : i / 4;
      check_output("tl_step", 8'(time_lock_out), 8'(exp_tl));
      check_output("tl_done", 8'(all_done), (i == 16) ? 8'd1 : 8'd0);
    end
    check_output("tl_alarm", 8'(alarm), 8'd0);
  endtask

  initial begin
    // Happy path, then inputs are ignored once open
    apply_reset();
    happy_to_timelock();
    check_outs("tl_entry", 2'd0, 1'b0, 1'b0);
    check_timelock();
    dir_in = 3'b111; plate_in = 8'h55; switch_in = 4'b1101; code_in = 1'b1;
    tick(5);
    check_outs("done_hold", 2'd3, 1'b1, 1'b0);

    // Overlapping code; an early SWITCH entry would race into MAZE on 111
    apply_reset();
    switch_in = 4'b1101;
    dir_in    = 3'b111;
    send_code(8'b0010_1011, 6);
    tick(1);
    switch_in = 4'b0000;
    maze_walk(1);
    plate_in = 8'h55;
    tick(1);
    check_output("ovl_err1_alarm", 8'(alarm), 8'd0);
    tick(1);
    check_output("ovl_err2_alarm", 8'(alarm), 8'd0);
    plate_walk(1, 0);
    tick(16);
    check_outs("ovl_open", 2'd3, 1'b1, 1'b0);

    // Three wrong maze entries latch the alarm
    apply_reset();
    send_code(8'b0000_1011, 4);
    open_switch();
    dir_in = 3'b111;
    tick(2);
    check_output("maze_err2_alarm", 8'(alarm), 8'd0);
    tick(1);
    check_outs("maze_err3", 2'd0, 1'b0, 1'b1);
    dir_in = 3'b000;
    tick(50);
    check_outs("maze_alarm_sticky", 2'd0, 1'b0, 1'b1);

    // Error count carries from MAZE into PLATES
    apply_reset();
    send_code(8'b0000_1011, 4);
    open_switch();
    dir_in = 3'b000;
    tick(1);
    dir_in = 3'b111;
    tick(1);
    check_output("cross_err1_alarm", 8'(alarm), 8'd0);
    maze_walk(1);
    plate_in = 8'h55;
    tick(1);
    check_output("cross_err2_alarm", 8'(alarm), 8'd0);
    tick(1);
    check_outs("cross_err3", 2'd0, 1'b0, 1'b1);

    // Held values and idle plates between entries are not errors
    apply_reset();
    send_code(8'b0000_1011, 4);
    open_switch();
    maze_walk(3);
    plate_walk(3, 1);
    tick(20);
    check_outs("hold_open", 2'd3, 1'b1, 1'b0);

    // Asynchronous reset in the middle of the time lock
    apply_reset();
    happy_to_timelock();
    tick(8);
    check_output("mid_tl_before", 8'(time_lock_out), 8'd2);
    #2;
    reset = 1'b0;
    #1;
    check_outs("mid_async", 2'd0, 1'b0, 1'b0);
    tick(2);
    reset = 1'b1;
    happy_to_timelock();
    check_timelock();

    // Stalling in SWITCH
    apply_reset();
    send_code(8'b0000_1011, 4);
    tick(63);
    check_output("stall63_alarm", 8'(alarm), 8'd0);
    tick(1);
`ifdef VAULT_TIMEOUT_EN
    check_output("stall64_alarm", 8'(alarm), 8'd1);
`else
    check_output("stall64_alarm", 8'(alarm), 8'd0);
`endif
    tick(6);
`ifdef VAULT_TIMEOUT_EN
    check_output("stall70_alarm", 8'(alarm), 8'd1);
`else
    check_output("stall70_alarm", 8'(alarm), 8'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
